// File: rtl/rgb_layer_ctrl.sv
// rgb_layer_ctrl
// Pixel compositor controller for the VGA display path. It picks one colour
// per pixel from four overlay layers: waveform, grid, info and ball.
// Configuration is written into shadow registers. The shadow set is copied
// to the active set only on frame_start, so a visible frame never mixes two
// configurations.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle pulse at the start of vertical blank
//   vidon        visible-area flag
//   layer_on     layer hit flags (bit0 waveform, bit1 grid, bit2 info, bit3 ball)
//   cfg_valid    config write request
//   cfg_ready    config write accept (low during frame_start)
//   cfg_addr     config register address
//   cfg_data     config write data
//   cfg_pending  shadow holds writes that are not yet committed
//   rgb          registered 4:4:4 pixel colour, two cycles after its inputs
//
// Register map (shadow and active copies):
//   0..3  layer colours
//   4     priority, four 2-bit layer indices, bits[1:0] = highest slot
//   5     bits[3:0] layer enable, bits[7:4] blink enable
//   6     background colour
//   7     reserved: writes are accepted and dropped

module rgb_layer_ctrl #(
  parameter int unsigned BLINK_FRAMES = 30  // frames per blink half-period, 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        vidon,
  input  logic [3:0]  layer_on,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_data,
  output logic        cfg_pending,
  output logic [11:0] rgb
);

  localparam logic [3:0][11:0] RST_COLS  = {12'hF00, 12'hFF0, 12'h999, 12'h0F0};
  localparam logic [7:0]       RST_PRIO  = 8'hE4;
  localparam logic [3:0]       RST_EN    = 4'hF;
  localparam logic [3:0]       RST_BLINK = 4'h0;
  localparam logic [11:0]      RST_BG    = 12'h000;
  localparam logic [7:0]       BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // shadow set
  logic [3:0][11:0] sh_col;
  logic [7:0]       sh_prio;
  logic [3:0]       sh_en;
  logic [3:0]       sh_blink;
  logic [11:0]      sh_bg;

  // active set
  logic [3:0][11:0] act_col;
  logic [7:0]       act_prio;
  logic [3:0]       act_en;
  logic [3:0]       act_blink;
  logic [11:0]      act_bg;

  logic        cfg_write;
  logic        pending_q;
  logic [7:0]  blink_cnt;
  logic        blink_phase;
  logic [3:0]  eff;
  logic        s1_vid;
  logic [3:0]  s1_eff;
  logic [11:0] pix;
  logic        hit;
  logic [1:0]  idx;
  logic [11:0] rgb_q;

  // Writes are refused during frame_start so a write can never race the
  // commit. A held request simply lands one cycle later.
  assign cfg_ready = ~frame_start;
  assign cfg_write = cfg_valid & cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_col   <= RST_COLS;
      sh_prio  <= RST_PRIO;
      sh_en    <= RST_EN;
      sh_blink <= RST_BLINK;
      sh_bg    <= RST_BG;
    end else if (cfg_write) begin
      case (cfg_addr)
        3'd0, 3'd1, 3'd2, 3'd3: sh_col[cfg_addr[1:0]] <= cfg_data;
        3'd4:    sh_prio <= cfg_data[7:0];
        3'd5:    {sh_blink, sh_en} <= cfg_data[7:0];
        3'd6:    sh_bg <= cfg_data;
        default: ;
      endcase
    end
  end

  // Writes to the reserved address leave nothing to commit, so they do not
  // raise pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (frame_start) begin
      pending_q <= 1'b0;
    end else if (cfg_write && (cfg_addr != 3'd7)) begin
      pending_q <= 1'b1;
    end
  end

  assign cfg_pending = pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_col   <= RST_COLS;
      act_prio  <= RST_PRIO;
      act_en    <= RST_EN;
      act_blink <= RST_BLINK;
      act_bg    <= RST_BG;
    end else if (frame_start) begin
      act_col   <= sh_col;
      act_prio  <= sh_prio;
      act_en    <= sh_en;
      act_blink <= sh_blink;
      act_bg    <= sh_bg;
    end
  end

  // The frame counter runs whether or not any layer blinks. The blink
  // enables only mask layers, so enabling blink later starts in a phase
  // that is already running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= 8'd0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt >= BLINK_LAST) begin
        blink_cnt   <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  assign eff = layer_on & act_en & ~(act_blink & {4{blink_phase}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vid <= 1'b0;
      s1_eff <= 4'h0;
    end else begin
      s1_vid <= vidon;
      s1_eff <= eff;
    end
  end

  // Walk the priority slots from highest to lowest and take the first hit.
  // Duplicate indices just re-test the same layer. A layer that is missing
  // from the order can never win.
  always_comb begin
    pix = act_bg;
    hit = 1'b0;
    idx = 2'd0;
    for (int s = 0; s < 4; s++) begin
      idx = act_prio[2*s +: 2];
      if (!hit && s1_eff[idx]) begin
        pix = act_col[idx];
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= s1_vid ? pix : 12'h000;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_rgb_layer_ctrl.sv
// tb_rgb_layer_ctrl
// Self-checking bench for rgb_layer_ctrl. It runs directed scenarios and
// then randomized traffic. A reference model tracks the shadow and active
// configuration, the blink frame count and the two-cycle output delay.
// frame_start is always driven during blank (vidon=0), which matches how a
// real timing generator behaves.

module tb_rgb_layer_ctrl;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        vidon;
  logic [3:0]  layer_on;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        cfg_pending;
  logic [11:0] rgb;

  int total = 0;
  int bad   = 0;

  // model state
  logic [11:0] m_shadow [0:6];
  logic [11:0] m_active [0:6];
  logic        m_pend;
  int          m_cnt;
  logic        m_phase;
  logic [11:0] m_s1;
  logic [11:0] m_rgb;

  always #5 clk = ~clk;

  rgb_layer_ctrl #(.BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .vidon       (vidon),
    .layer_on    (layer_on),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_pending (cfg_pending),
    .rgb         (rgb)
  );

  function automatic void model_reset();
    m_shadow = '{12'h0F0, 12'h999, 12'hFF0, 12'hF00, 12'h0E4, 12'h00F, 12'h000};
    m_active = m_shadow;
    m_pend   = 1'b0;
    m_cnt    = 0;
    m_phase  = 1'b0;
    m_s1     = 12'h000;
    m_rgb    = 12'h000;
  endfunction

  // Colour of one pixel from the active set: first layer in the priority
  // order that is hit, enabled and not blanked by blink, else background.
  function automatic logic [11:0] model_pixel(input logic v, input logic [3:0] lon);
    bit vis [0:3];
    int layer;
    if (!v) return 12'h000;
    for (int i = 0; i < 4; i++)
      vis[i] = lon[i] && m_active[5][i] && !(m_active[5][4+i] && m_phase);
    for (int s = 0; s < 4; s++) begin
      layer = (int'(m_active[4]) >> (2 * s)) % 4;
      if (vis[layer]) return m_active[layer];
    end
    return m_active[6];
  endfunction

  function automatic void model_edge();
    m_rgb = m_s1;
    m_s1  = model_pixel(vidon, layer_on);
    if (frame_start) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
      m_cnt    = m_cnt + 1;
      if (m_cnt == BF) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end
    end else if (cfg_valid) begin
      if (cfg_addr == 3'd4 || cfg_addr == 3'd5)
        m_shadow[cfg_addr] = {4'h0, cfg_data[7:0]};
      else if (cfg_addr != 3'd7)
        m_shadow[cfg_addr] = cfg_data;
      if (cfg_addr != 3'd7) m_pend = 1'b1;
    end
  endfunction

  task automatic check_output(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  // Frame_start cycles are always blank.
  task automatic apply_stimulus(input logic fs, input logic v, input logic [3:0] lon);
    frame_start = fs;
    vidon       = fs ? 1'b0 : v;
    layer_on    = lon;
    #1;
    check_output("cfg_ready", {11'h0, cfg_ready}, {11'h0, ~fs});
    tick();
    check_output("rgb", rgb, m_rgb);
    check_output("cfg_pending", {11'h0, cfg_pending}, {11'h0, m_pend});
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [11:0] d, input logic [3:0] lon);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    apply_stimulus(1'b0, 1'b1, lon);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int on_frames;
    logic fs;

    rst_n       = 1'b0;
    frame_start = 1'b0;
    vidon       = 1'b0;
    layer_on    = 4'h0;
    cfg_valid   = 1'b0;
    cfg_addr    = 3'd0;
    cfg_data    = 12'h000;
    model_reset();

    @(negedge clk);
    check_output("reset_rgb", rgb, 12'h000);
    check_output("reset_pending", {11'h0, cfg_pending}, 12'h000);
    check_output("reset_ready", {11'h0, cfg_ready}, 12'h001);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] default colours");
    repeat (3) apply_stimulus(1'b0, 1'b1, 4'b0011);
    check_output("tp_wave", rgb, 12'h0F0);
    repeat (2) apply_stimulus(1'b0, 1'b1, 4'b0010);
    check_output("tp_grid", rgb, 12'h999);
    repeat (2) apply_stimulus(1'b0, 1'b1, 4'b0000);
    check_output("tp_none", rgb, 12'h000);
    repeat (2) apply_stimulus(1'b0, 1'b0, 4'b1111);
    check_output("tp_blank", rgb, 12'h000);

    $display("[TB] priority change waits for frame");
    cfg_write(3'd4, 12'h01B, 4'hF);
    repeat (3) apply_stimulus(1'b0, 1'b1, 4'hF);
    check_output("tp_prio_old", rgb, 12'h0F0);
    check_output("tp_prio_pend", {11'h0, cfg_pending}, 12'h001);
    apply_stimulus(1'b1, 1'b0, 4'hF);
    check_output("tp_commit_pend", {11'h0, cfg_pending}, 12'h000);
    repeat (2) apply_stimulus(1'b0, 1'b1, 4'hF);
    check_output("tp_prio_new", rgb, 12'hF00);

    $display("[TB] write held across frame_start");
    cfg_valid = 1'b1;
    cfg_addr  = 3'd0;
    cfg_data  = 12'h00F;
    apply_stimulus(1'b1, 1'b0, 4'b0001);
    apply_stimulus(1'b0, 1'b1, 4'b0001);
    cfg_valid = 1'b0;
    check_output("tp_held_pend", {11'h0, cfg_pending}, 12'h001);
    repeat (2) apply_stimulus(1'b0, 1'b1, 4'b0001);
    check_output("tp_held_old", rgb, 12'h0F0);
    apply_stimulus(1'b1, 1'b0, 4'b0001);
    repeat (2) apply_stimulus(1'b0, 1'b1, 4'b0001);
    check_output("tp_held_new", rgb, 12'h00F);

    $display("[TB] blink");
    cfg_write(3'd5, 12'h04F, 4'b0100);
    apply_stimulus(1'b1, 1'b0, 4'b0100);
    on_frames = 0;
    for (int f = 0; f < 8; f++) begin
      apply_stimulus(1'b1, 1'b0, 4'b0100);
      repeat (3) apply_stimulus(1'b0, 1'b1, 4'b0100);
      if (rgb == 12'hFF0) on_frames++;
    end
    check_output("tp_blink_on", 12'(on_frames), 12'd4);

    $display("[TB] disable and background");
    cfg_write(3'd5, 12'h00D, 4'b0010);
    cfg_write(3'd6, 12'h123, 4'b0010);
    apply_stimulus(1'b1, 1'b0, 4'b0010);
    repeat (2) apply_stimulus(1'b0, 1'b1, 4'b0010);
    check_output("tp_bg", rgb, 12'h123);
    cfg_write(3'd7, 12'hABC, 4'b0010);
    apply_stimulus(1'b0, 1'b1, 4'b0010);
    check_output("tp_reserved", {11'h0, cfg_pending}, 12'h000);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      fs = ($urandom_range(0, 11) == 0);
      if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_addr  = 3'($urandom_range(0, 7));
        cfg_data  = 12'($urandom);
      end
      apply_stimulus(fs, 1'($urandom), 4'($urandom));
      if (!fs) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;

    $display("[TB] reset mid-frame");
    cfg_write(3'd3, 12'h0AA, 4'hF);
    cfg_write(3'd4, 12'h0E4, 4'hF);
    apply_stimulus(1'b1, 1'b0, 4'hF);
    cfg_write(3'd6, 12'h555, 4'hF);
    repeat (2) apply_stimulus(1'b0, 1'b1, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("rst_rgb", rgb, 12'h000);
    check_output("rst_pending", {11'h0, cfg_pending}, 12'h000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) apply_stimulus(1'b0, 1'b1, 4'b1000);
    check_output("rst_ball", rgb, 12'hF00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
